// File: rtl/seg7_text_decoder.sv
// Samples a 7-segment bus, waits for each pattern to settle, decodes new glyphs to ASCII
// and queues them in a small FIFO. Define SEG7DEC_MARKER_EN to turn the dp-only marker into a newline.
module seg7_text_decoder #(
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned FIFO_DEPTH    = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [7:0]                    seg_in,
  input  logic                          clr,
  output logic [7:0]                    char_data,
  output logic                          char_valid,
  input  logic                          char_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          err,
  output logic                          ovf
);

  localparam int unsigned CW = $clog2(STABLE_CYCLES);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] CNT_MAX  = CW'(STABLE_CYCLES - 1);
  localparam logic [AW:0]   LVL_FULL = (AW + 1)'(FIFO_DEPTH);
  localparam logic [AW:0]   LVL_ONE  = (AW + 1)'(1);

  logic [7:0]    r_sync1;
  logic [7:0]    r_sync2;
  logic [7:0]    r_cand;
  logic [CW-1:0] r_cnt;
  logic [7:0]    r_acc;
  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr;
  logic [AW-1:0] r_rd;
  logic [AW:0]   r_level;
  logic [7:0]    r_char_data;
  logic          r_char_valid;
  logic          r_err;
  logic          r_ovf;

  logic          w_accept;
  logic          w_is_char;
  logic          w_bad;
  logic [7:0]    w_ascii;
  logic          w_push_req;
  logic          w_pop;
  logic          w_full;
  logic          w_push;
  logic          w_drop;
  logic [AW:0]   w_level_nxt;
  logic [AW-1:0] w_rd_nxt;
  logic [7:0]    w_head_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= seg_in;
      r_sync2 <= r_sync1;
    end
  end

  // Settle filter: counter restarts on any change and saturates once stable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cand <= '0;
      r_cnt  <= '0;
      r_acc  <= '0;
    end else begin
      if (r_sync2 != r_cand) begin
        r_cand <= r_sync2;
        r_cnt  <= '0;
      end else if (r_cnt < CNT_MAX) begin
        r_cnt <= r_cnt + CW'(1);
      end
      if (w_accept) r_acc <= r_cand;
    end
  end

  assign w_accept = (r_cnt == CNT_MAX) && (r_sync2 == r_cand) && (r_cand != r_acc);

  // Classification of the newly accepted pattern (r_cand becomes the new acc).
  always_comb begin
    w_is_char = 1'b1;
    w_bad     = 1'b0;
    w_ascii   = 8'h3F;
    case (r_cand)
      8'h00: w_is_char = 1'b0;
      8'h80: begin
`ifdef SEG7DEC_MARKER_EN
        w_ascii = 8'h0A;
`else
        w_is_char = 1'b0;
`endif
      end
      8'h5B: w_ascii = 8'h53;
      8'h4F: w_ascii = 8'h45;
      8'h15: w_ascii = 8'h6E;
      8'h7E: w_ascii = 8'h4F;
      8'h0E: w_ascii = 8'h4C;
      8'h5F: w_ascii = 8'h47;
      8'h3E: w_ascii = 8'h55;
      8'h77: w_ascii = 8'h41;
      8'h1F: w_ascii = 8'h62;
      8'h4E: w_ascii = 8'h43;
      8'h3D: w_ascii = 8'h64;
      8'h37: w_ascii = 8'h48;
      8'h67: w_ascii = 8'h50;
      8'h30: w_ascii = 8'h31;
      8'h6D: w_ascii = 8'h32;
      8'h79: w_ascii = 8'h33;
      8'h33: w_ascii = 8'h34;
      8'h70: w_ascii = 8'h37;
      8'h7F: w_ascii = 8'h38;
      default: w_bad = 1'b1;
    endcase
  end

  assign w_push_req = w_accept && w_is_char;
  assign w_pop      = r_char_valid && char_ready;
  assign w_full     = (r_level == LVL_FULL);
  assign w_push     = w_push_req && (!w_full || w_pop);
  assign w_drop     = w_push_req && w_full && !w_pop;

  // Registered head: a push into an empty (or draining-to-empty) FIFO bypasses the memory.
  always_comb begin
    w_level_nxt = r_level;
    case ({w_push, w_pop})
      2'b10:   w_level_nxt = r_level + LVL_ONE;
      2'b01:   w_level_nxt = r_level - LVL_ONE;
      default: w_level_nxt = r_level;
    endcase
    w_rd_nxt = w_pop ? r_rd + AW'(1) : r_rd;
    if (w_level_nxt == '0)
      w_head_nxt = '0;
    else if ((r_level == '0) || (w_pop && (r_level == LVL_ONE)))
      w_head_nxt = w_ascii;
    else
      w_head_nxt = r_mem[w_rd_nxt];
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= w_ascii;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr         <= '0;
      r_rd         <= '0;
      r_level      <= '0;
      r_char_data  <= '0;
      r_char_valid <= 1'b0;
      r_err        <= 1'b0;
      r_ovf        <= 1'b0;
    end else begin
      if (w_push) r_wr <= r_wr + AW'(1);
      r_rd         <= w_rd_nxt;
      r_level      <= w_level_nxt;
      r_char_data  <= w_head_nxt;
      r_char_valid <= (w_level_nxt != '0);
      r_err        <= (w_accept && w_bad) || (r_err && !clr);
      r_ovf        <= w_drop || (r_ovf && !clr);
    end
  end

  assign char_data  = r_char_data;
  assign char_valid = r_char_valid;
  assign fifo_level = r_level;
  assign err        = r_err;
  assign ovf        = r_ovf;

endmodule

// File: tb/tb_seg7_text_decoder.sv
// Scoreboard bench for seg7_text_decoder: a run-length reference model predicts characters,
// a monitor pops and compares them whenever the DUT hands one over.
module tb_seg7_text_decoder;
  localparam int unsigned SC = 4;
  localparam int unsigned FD = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] seg_in = 8'h00;
  logic       clr = 1'b0;
  logic       char_ready = 1'b0;
  logic [7:0] char_data;
  logic       char_valid;
  logic [2:0] fifo_level;
  logic       err;
  logic       ovf;

  int checks = 0;
  int errors = 0;

  logic [7:0] sb[$];

  logic [7:0] g_pat [19] = '{8'h5B, 8'h4F, 8'h15, 8'h7E, 8'h0E, 8'h5F, 8'h3E, 8'h77, 8'h1F, 8'h4E,
                             8'h3D, 8'h37, 8'h67, 8'h30, 8'h6D, 8'h79, 8'h33, 8'h70, 8'h7F};
  logic [7:0] g_asc [19] = '{"S", "E", "n", "O", "L", "G", "U", "A", "b", "C",
                             "d", "H", "P", "1", "2", "3", "4", "7", "8"};

  // Reference model: a pattern counts once it has been held SC+1 cycles in one run.
  logic [7:0] m_cur = 8'h00;
  logic [7:0] m_acc = 8'h00;
  int         m_run = 0;
  bit         m_err = 1'b0;
  bit         m_ovf = 1'b0;
  bit         m_force = 1'b0;

  always #5 clk = ~clk;

  seg7_text_decoder #(.STABLE_CYCLES(SC), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .rst_n(rst_n), .seg_in(seg_in), .clr(clr),
    .char_data(char_data), .char_valid(char_valid), .char_ready(char_ready),
    .fifo_level(fifo_level), .err(err), .ovf(ovf)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic void decode(input logic [7:0] p, output bit is_char, output bit bad,
                                 output logic [7:0] a);
    is_char = 1'b0; bad = 1'b0; a = 8'h00;
    if (p == 8'h00) return;
    if (p == 8'h80) begin
`ifdef SEG7DEC_MARKER_EN
      is_char = 1'b1; a = 8'h0A;
`endif
      return;
    end
    for (int i = 0; i < 19; i++)
      if (g_pat[i] == p) begin
        is_char = 1'b1; a = g_asc[i];
        return;
      end
    is_char = 1'b1; bad = 1'b1; a = 8'h3F;
  endfunction

  function automatic void m_hold(input logic [7:0] p, input int n);
    bit ic, bd;
    logic [7:0] a;
    if (p != m_cur) begin
      m_cur = p;
      m_run = 0;
    end
    m_run += n;
    if (m_run >= SC + 1 && m_cur != m_acc) begin
      m_acc = m_cur;
      decode(m_cur, ic, bd, a);
      if (ic) begin
        if (bd) m_err = 1'b1;
        if (sb.size() < FD || m_force) sb.push_back(a);
        else m_ovf = 1'b1;
      end
    end
  endfunction

  task automatic drive_seg(input logic [7:0] p, input int n, input bit rnd);
    seg_in = p;
    m_hold(p, n);
    for (int i = 0; i < n; i++) begin
      if (rnd) char_ready = ($urandom_range(0, 1) == 1) || (i % 3 == 0);
      @(posedge clk); #1;
    end
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    m_err = 1'b0;
    m_ovf = 1'b0;
    m_hold(seg_in, 1);
    @(posedge clk); #1;
    clr = 1'b0;
  endtask

  task automatic drain(input string tag);
    char_ready = 1'b1;
    drive_seg(8'h00, 12, 1'b0);
    check({tag, "_sb_empty"}, sb.size(), 0);
    check({tag, "_valid"}, char_valid, 0);
    check({tag, "_level"}, fifo_level, 0);
    char_ready = 1'b0;
  endtask

  // Monitor: every handshake consumes the oldest expected character.
  initial begin
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (rst_n && char_valid && char_ready) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_char actual=%0h required=none", char_data);
        end else begin
          e = sb.pop_front();
          check("char_data", char_data, e);
        end
      end else if (rst_n && !char_valid) begin
        check("empty_data_zero", char_data, 0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] p;
    int r;
    #1;
    check("rst_data", char_data, 0);
    check("rst_valid", char_valid, 0);
    check("rst_level", fifo_level, 0);
    check("rst_err", err, 0);
    check("rst_ovf", ovf, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Single glyph, consumer always ready: valid exactly after edge 7.
    char_ready = 1'b1;
    seg_in = 8'h5B;
    m_hold(8'h5B, 11);
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk);
      @(negedge clk);
      check($sformatf("p1_valid_edge%0d", k), char_valid, (k == 7) ? 1 : 0);
    end
    @(posedge clk); #1;
    check("p1_err", err, 0);
    drain("p1");

    // Repeated letter separated by blank.
    drive_seg(8'h0E, 8, 1'b0);
    drive_seg(8'h00, 8, 1'b0);
    drive_seg(8'h0E, 8, 1'b0);
    check("p2_level", fifo_level, 2);
    check("p2_head", char_data, 8'h4C);
    drain("p2");

    // Short glitch between blanks.
    drive_seg(8'h00, 8, 1'b0);
    drive_seg(8'h5F, 3, 1'b0);
    drive_seg(8'h00, 8, 1'b0);
    check("p3_level", fifo_level, 0);
    check("p3_sb", sb.size(), 0);

    // Undecodable pattern, then clear.
    drive_seg(8'h01, 8, 1'b0);
    check("p4_level", fifo_level, 1);
    check("p4_head", char_data, 8'h3F);
    check("p4_err", err, 1);
    pulse_clr();
    check("p4_err_clr", err, 0);
    check("p4_level_kept", fifo_level, 1);
    drain("p4");

    // Overflow with five glyphs.
    drive_seg(8'h5B, 8, 1'b0); drive_seg(8'h00, 8, 1'b0);
    drive_seg(8'h4F, 8, 1'b0); drive_seg(8'h00, 8, 1'b0);
    drive_seg(8'h15, 8, 1'b0); drive_seg(8'h00, 8, 1'b0);
    drive_seg(8'h7E, 8, 1'b0); drive_seg(8'h00, 8, 1'b0);
    drive_seg(8'h77, 8, 1'b0); drive_seg(8'h00, 8, 1'b0);
    check("p5_level_full", fifo_level, 4);
    check("p5_ovf", ovf, 1);
    check("p5_head", char_data, 8'h53);
    check("p5_ovf_model", ovf, m_ovf);
    // Pop coinciding with the push edge of a new glyph while full.
    m_force = 1'b1;
    seg_in = 8'h37;
    m_hold(8'h37, 7);
    m_force = 1'b0;
    repeat (6) begin @(posedge clk); #1; end
    char_ready = 1'b1;
    @(posedge clk); #1;
    char_ready = 1'b0;
    check("p5_level_pushpop", fifo_level, 4);
    check("p5_head_after_pop", char_data, 8'h45);
    check("p5_ovf_sticky", ovf, 1);
    pulse_clr();
    check("p5_ovf_clr", ovf, 0);
    drain("p5");

    // Marker, undecodable dp pattern, then reset mid-stream.
    drive_seg(8'h80, 8, 1'b0);
    check("p6_marker_level", fifo_level, sb.size());
    check("p6_marker_head", char_data, (sb.size() != 0) ? int'(sb[0]) : 0);
    check("p6_marker_err", err, 0);
    drive_seg(8'h00, 8, 1'b0);
    drive_seg(8'h81, 8, 1'b0);
    drive_seg(8'h00, 8, 1'b0);
    drive_seg(8'h77, 8, 1'b0);
    check("p6_level", fifo_level, sb.size());
    check("p6_err", err, 1);
    rst_n = 1'b0;
    #1;
    check("p6_rst_data", char_data, 0);
    check("p6_rst_valid", char_valid, 0);
    check("p6_rst_level", fifo_level, 0);
    check("p6_rst_err", err, 0);
    check("p6_rst_ovf", ovf, 0);
    sb.delete();
    m_acc = 8'h00; m_cur = 8'h77; m_run = 0; m_err = 1'b0; m_ovf = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    char_ready = 1'b1;
    drive_seg(8'h77, 10, 1'b0);
    check("p6_reemit", sb.size(), 0);
    drain("p6");

    // Randomized stream against the model.
    for (int s = 0; s < 150; s++) begin
      r = $urandom_range(0, 9);
      if (r < 4)       p = 8'h00;
      else if (r < 8)  p = g_pat[$urandom_range(0, 18)];
      else if (r == 8) p = 8'h80;
      else             p = 8'($urandom_range(0, 255));
      drive_seg(p, $urandom_range(1, 9), 1'b1);
    end
    drain("rnd");
    check("rnd_err", err, m_err);
    check("rnd_ovf", ovf, m_ovf);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/seg7_text_decoder.md
# seg7_text_decoder

Receive-side counterpart of the scrolling 7-segment text generator: samples an 8-bit segment bus, waits for each pattern to settle, decodes each new glyph back to ASCII and queues the characters in a small FIFO behind a valid/ready handshake. It sits at the chip's input pins. It lets a second die, or a bench, read back the text a scroller is displaying. It also serves as a loopback checker for the display path.

## Interface
- STABLE_CYCLES, 4: consecutive identical synchronised samples required to accept a pattern (legal range 2..255).
- FIFO_DEPTH, 4: character FIFO entries (power of two, 2..16).
- clk  input  1  clock.
- rst_n  input  1  reset, asynchronous, active-low.
- seg_in  input  8  segment bus, bit7=dp, bit6..bit0 = a,b,c,d,e,f,g; asynchronous to clk.
- clr  input  1  synchronous pulse; clears err and ovf.
- char_data  output  8  ASCII code at FIFO head; 0x00 when empty.
- char_valid  output  1  FIFO non-empty.
- char_ready  input  1  consumer accepts head when char_valid && char_ready.
- fifo_level  output  $clog2(FIFO_DEPTH)+1  current occupancy.
- err  output  1  sticky: an undecodable pattern was accepted.
- ovf  output  1  sticky: a character was dropped because the FIFO was full.

## Operation
- seg_in passes through a 2-flop synchroniser. Decoding uses only the second stage (sync).
- Settle filter:
  - Registers cand (8b) and cnt.
  - If sync != cand: cand<=sync, cnt<=0.
  - Else if cnt < STABLE_CYCLES-1: cnt++.
  - cnt saturates.
- Accept event: cnt==STABLE_CYCLES-1, sync==cand and cand != acc. On the event, acc<=cand.
  - The event fires once per new stable pattern.
  - A pattern that is held never re-fires.
- Event classification, using the new acc value:
  - 0x00 (blank): no output. Acts as the separator that allows repeated letters.
  - 0x80 (dp only): message marker; behaviour per Configuration.
  - Any other value with dp=1: undecodable.
  - Glyph table (value -> ASCII):
    - 0x5B->'S', 0x4F->'E', 0x15->'n', 0x7E->'O', 0x0E->'L', 0x5F->'G', 0x3E->'U'.
    - 0x77->'A', 0x1F->'b', 0x4E->'C', 0x3D->'d', 0x37->'H', 0x67->'P'.
    - 0x30->'1', 0x6D->'2', 0x79->'3', 0x33->'4', 0x70->'7', 0x7F->'8'.
  - Any other pattern: push 0x3F ('?') and set err.
- FIFO:
  - Push on a classified character event.
  - Pop on char_valid && char_ready.
  - Full and push without pop: character dropped, ovf<=1, contents unchanged.
  - Full with simultaneous push and pop: both succeed, level unchanged.
  - Pop when empty: ignored.
  - Pointers wrap modulo FIFO_DEPTH.
- clr clears err/ovf. If a set condition occurs in the same cycle as clr, the flag ends set. clr does not flush the FIFO.

## Timing
- Reset values:
  - sync stages, cand, acc = 0x00; cnt = 0.
  - FIFO empty, fifo_level = 0, char_valid = 0, char_data = 0x00, err = 0, ovf = 0.
- Latency: new pattern present before edge 1 -> cand loaded at edge 3 -> push at edge STABLE_CYCLES+3.
  - char_valid high after that edge if the FIFO was empty (edge 7 for default).
- A glitch shorter than STABLE_CYCLES+1 cycles produces no event and leaves acc unchanged.
- char_data/char_valid are registered FIFO-head outputs. The next entry appears the cycle after a pop.
- Reset mid-operation discards FIFO contents and acc. A glyph held through reset release is re-emitted after STABLE_CYCLES+3 edges.

## Configuration
- SEG7DEC_MARKER_EN defined: a 0x80 event pushes 0x0A (newline).
- SEG7DEC_MARKER_EN undefined: a 0x80 event behaves as blank (acc updated, nothing pushed, err unaffected).

## Test plan
- Hold 0x5B for 10 cycles, char_ready=1 -> single char 0x53 at edge 7, char_valid for one cycle, err=0.
- Drive 0x0E, 0x00, 0x0E, each held 8 cycles, char_ready=0 -> FIFO holds 0x4C,0x4C, fifo_level=2.
- Drive 0x5F for 3 cycles between two 0x00 periods -> nothing pushed, fifo_level=0.
- Drive 0x01 held 8 cycles -> char 0x3F, err=1; pulse clr -> err=0.
- char_ready=0, drive 5 distinct glyphs separated by blanks -> fifo_level=4, ovf=1, head=first glyph. Then pop with a simultaneous push while full -> level stays 4.
- Drive 0x80 held 8 cycles -> 0x0A with SEG7DEC_MARKER_EN, no char without. Assert rst_n low mid-stream -> all outputs return to reset values immediately.
